// File: rtl/pulse_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_meter_pkg
// Description : Shared types and default sizes for the pulse propagation time
//               meter (edge detectors, interval meter, result readout).
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_meter_pkg;

    // Interval meter state encoding
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        COUNTING = 2'd2,
        REPORT   = 2'd3
    } meter_state_t;

    // Default sizes shared by every block of the meter
    localparam int unsigned c_count_w_default        = 16;
    localparam int unsigned c_timeout_cycles_default = 50000;

endpackage : pulse_meter_pkg
`default_nettype wire

// File: rtl/pulse_interval_meter.sv
`default_nettype none
// ============================================================================
// Module      : pulse_interval_meter
// Description : Measures the number of clock cycles between a single-cycle
//               start pulse and a single-cycle stop pulse, reporting the
//               interval with a one-cycle valid strobe or a timeout strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_interval_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned COUNT_W        = c_count_w_default,
    parameter int unsigned TIMEOUT_CYCLES = c_timeout_cycles_default,
    parameter bit          AUTO_REARM     = 1'b0
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Arm,
    input  logic               i_Start,
    input  logic               i_Stop,
    output logic               o_Armed,
    output logic               o_Busy,
    output logic [COUNT_W-1:0] o_Count,
    output logic               o_Valid,
    output logic               o_Timeout
);

    // Timeout limit at counter width; the limit never exceeds the counter's
    // range, so the counter stops before it could wrap.
    localparam logic [COUNT_W-1:0] c_timeout = COUNT_W'(TIMEOUT_CYCLES);

    meter_state_t        r_state;
    meter_state_t        w_next_state;
    logic [COUNT_W-1:0]  r_counter;
    logic [COUNT_W-1:0]  w_counter_next;
    logic [COUNT_W-1:0]  r_count;
    logic [COUNT_W-1:0]  w_result;
    logic                r_valid;
    logic                r_timeout;
    logic                w_finish;
    logic                w_good;

    // Next-state, counter update and result selection
    always_comb begin
        w_next_state   = r_state;
        w_counter_next = r_counter;
        w_result       = r_counter;
        w_finish       = 1'b0;
        w_good         = 1'b0;
        case (r_state)
            IDLE: begin
                w_counter_next = '0;
                if (i_Arm) begin
                    w_next_state = ARMED;
                end
            end
            ARMED: begin
                // A stop without a start is a stale arrival and is dropped
                if (i_Start) begin
                    if (i_Stop) begin
                        w_next_state = REPORT;
                        w_finish     = 1'b1;
                        w_good       = 1'b1;
                        w_result     = '0;
                    end else begin
                        w_next_state   = COUNTING;
                        w_counter_next = COUNT_W'(1);
                    end
                end
            end
            COUNTING: begin
                // Stop wins over a coincident timeout
                if (i_Stop) begin
                    w_next_state = REPORT;
                    w_finish     = 1'b1;
                    w_good       = 1'b1;
                    w_result     = r_counter;
                end else if (r_counter == c_timeout) begin
                    w_next_state = REPORT;
                    w_finish     = 1'b1;
                    w_result     = c_timeout;
                end else begin
                    w_counter_next = r_counter + COUNT_W'(1);
                end
            end
            REPORT: begin
                w_counter_next = '0;
                w_next_state   = AUTO_REARM ? ARMED : IDLE;
            end
            default: begin
                w_next_state   = IDLE;
                w_counter_next = '0;
            end
        endcase
    end

    // State, counter and registered result/strobe outputs
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state   <= IDLE;
            r_counter <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_counter <= w_counter_next;
            r_valid   <= w_finish & w_good;
            r_timeout <= w_finish & ~w_good;
            if (w_finish) begin
                r_count <= w_result;
            end
        end
    end

    assign o_Armed   = (r_state == ARMED);
    assign o_Busy    = (r_state == ARMED) || (r_state == COUNTING);
    assign o_Count   = r_count;
    assign o_Valid   = r_valid;
    assign o_Timeout = r_timeout;

endmodule : pulse_interval_meter
`default_nettype wire

// File: tb/tb_pulse_interval_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_interval_meter
// Description : Self-checking bench for pulse_interval_meter; one single-shot
//               instance and one auto-rearm instance, directed plus random
//               measurements checked against an interval model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_interval_meter;

    localparam int unsigned c_cw = 8;
    localparam int          c_t  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic arm = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic sel = 1'b0;   // 0: single-shot instance, 1: auto-rearm instance

    int compared   = 0;
    int mismatched = 0;
    int auto_mode  = 0;

    logic            a0, b0, v0, t0, a1, b1, v1, t1;
    logic [c_cw-1:0] cnt0, cnt1;
    logic            w_armed, w_busy, w_valid, w_tmo;
    logic [c_cw-1:0] w_cnt;

    always #5 clk = ~clk;

    pulse_interval_meter #(.COUNT_W(c_cw), .TIMEOUT_CYCLES(c_t), .AUTO_REARM(1'b0)) dut0 (
        .i_Clk(clk), .i_Rst(rst), .i_Arm(arm & ~sel), .i_Start(start & ~sel),
        .i_Stop(stop & ~sel), .o_Armed(a0), .o_Busy(b0), .o_Count(cnt0),
        .o_Valid(v0), .o_Timeout(t0));

    pulse_interval_meter #(.COUNT_W(c_cw), .TIMEOUT_CYCLES(c_t), .AUTO_REARM(1'b1)) dut1 (
        .i_Clk(clk), .i_Rst(rst), .i_Arm(arm & sel), .i_Start(start & sel),
        .i_Stop(stop & sel), .o_Armed(a1), .o_Busy(b1), .o_Count(cnt1),
        .o_Valid(v1), .o_Timeout(t1));

    assign w_armed = sel ? a1 : a0;
    assign w_busy  = sel ? b1 : b0;
    assign w_valid = sel ? v1 : v0;
    assign w_tmo   = sel ? t1 : t0;
    assign w_cnt   = sel ? cnt1 : cnt0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic arm_it();
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("arm_armed", w_armed, 1);
        chk("arm_busy", w_busy, 1);
    endtask

    // One measurement: start, then stop n cycles later (n > c_t means the stop
    // arrives too late). Expected outcome comes straight from the interval
    // rule: result = min(n, c_t), good if n <= c_t, strobe seen right after the
    // edge that samples the stop (or the edge where the limit is reached).
    task automatic measure(input int n, input int gap, input bit stale);
        int  r;
        bit  good;
        int  last;
        r    = (n <= c_t) ? n : c_t;
        good = (n <= c_t);
        last = (n > r + 1) ? n : r + 1;
        chk("pre_armed", w_armed, 1);
        for (int g = 0; g < gap; g++) begin
            stop = stale && (g == 0);
            step();
            stop = 1'b0;
            chk("gap_armed", w_armed, 1);
            chk("gap_valid", w_valid, 0);
        end
        start = 1'b1;
        stop  = (n == 0);
        step();
        for (int j = 0; j <= last; j++) begin
            chk("valid", w_valid, (good && j == r) ? 1 : 0);
            chk("timeout", w_tmo, (!good && j == r) ? 1 : 0);
            if (j == r) chk("count", w_cnt, r);
            if (j < r)  chk("busy_counting", w_busy, 1);
            if (j == r) chk("busy_report", w_busy, 0);
            if (j == r + 1) begin
                chk("count_hold", w_cnt, r);
                chk("armed_after", w_armed, auto_mode);
                chk("busy_after", w_busy, auto_mode);
            end
            stop  = (j + 1 == n);
            start = (j + 1 <= r) && ($urandom_range(0, 3) == 0);
            step();
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int n;
        step(); step(); step();
        chk("rst_valid0", v0, 0);   chk("rst_tmo0", t0, 0);
        chk("rst_count0", cnt0, 0); chk("rst_armed0", a0, 0);
        chk("rst_busy0", b0, 0);    chk("rst_armed1", a1, 0);
        rst = 1'b0;
        // Start and stop pulses in IDLE are ignored
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0; step();
        chk("idle_ignore_valid", w_valid, 0);
        chk("idle_ignore_busy", w_busy, 0);

        // Single-shot directed cases
        sel = 1'b0; auto_mode = 0;
        arm_it(); measure(15, 9, 1'b0);
        arm_it(); measure(0, 1, 1'b0);
        arm_it(); measure(3, 5, 1'b1);
        arm_it(); measure(25, 0, 1'b0);
        arm_it(); measure(c_t, 2, 1'b0);
        arm_it(); measure(c_t - 1, 1, 1'b1);
        arm_it(); measure(1, 0, 1'b0);
        // Single-shot random cases
        for (int i = 0; i < 10; i++) begin
            n = $urandom_range(0, c_t + 4);
            arm_it();
            measure(n, $urandom_range(1, 3), $urandom_range(0, 1));
        end

        // Reset in the middle of counting aborts without a strobe
        arm_it();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("mid_busy", w_busy, 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mrst_count", w_cnt, 0);  chk("mrst_valid", w_valid, 0);
        chk("mrst_tmo", w_tmo, 0);    chk("mrst_busy", w_busy, 0);
        chk("mrst_armed", w_armed, 0);
        stop = 1'b1; step(); stop = 1'b0;
        step();
        chk("late_stop_valid", w_valid, 0);
        chk("late_stop_busy", w_busy, 0);
        chk("late_stop_count", w_cnt, 0);

        // Auto-rearm instance: consecutive measurements without re-arming
        sel = 1'b1; auto_mode = 1;
        step();
        arm_it();
        measure(4, 1, 1'b0);
        measure(7, 0, 1'b0);
        measure(1, 2, 1'b1);
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(0, c_t + 3);
            measure(n, $urandom_range(1, 3), $urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_pulse_interval_meter
`default_nettype wire
